// File: rtl/tpu_job_sequencer.sv
// rtl/tpu_job_sequencer.sv - in-order job queue with launch/monitor/report FSM for the TPU matmul engine
module tpu_job_sequencer #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int START_WAIT     = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     job_valid,
    output logic                     job_ready,
    input  logic [7:0]               job_K,
    input  logic [7:0]               job_M,
    input  logic [7:0]               job_N,
    input  logic [31:0]              job_offset,
    input  logic [3:0]               job_tag,
    output logic                     tpu_in_valid,
    output logic [7:0]               tpu_K,
    output logic [7:0]               tpu_M,
    output logic [7:0]               tpu_N,
    output logic [31:0]              tpu_offset,
    input  logic                     tpu_busy,
    output logic                     done_valid,
    input  logic                     done_ready,
    output logic [3:0]               done_tag,
    output logic [31:0]              done_cycles,
    output logic                     done_error,
    output logic [$clog2(DEPTH):0]   queue_count,
    output logic                     idle
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {IDLE, LAUNCH, START, RUN, DRAIN, REPORT} state_t;
    state_t state, state_next;

    logic [7:0]    q_k   [DEPTH];
    logic [7:0]    q_m   [DEPTH];
    logic [7:0]    q_n   [DEPTH];
    logic [31:0]   q_off [DEPTH];
    logic [3:0]    q_tag [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic [31:0]   cycles, wait_cnt;
    logic          push, pop, head_zero, busy_last, rec_set, rec_err;

    assign push         = job_valid && job_ready;
    assign pop          = (state == IDLE) && (count != '0) && !done_valid;
    assign head_zero    = (q_k[rd_ptr] == 8'd0) || (q_m[rd_ptr] == 8'd0) || (q_n[rd_ptr] == 8'd0);
    // True when the busy cycle being sampled now is the one that hits the timeout.
    assign busy_last    = (cycles == 32'(TIMEOUT_CYCLES - 1));
    assign tpu_in_valid = (state == LAUNCH);
    assign queue_count  = count;
    assign idle         = (state == IDLE) && (count == '0);
    assign done_cycles  = cycles;

    always_ff @(posedge clk) begin
        if (push) begin
            q_k[wr_ptr]   <= job_K;
            q_m[wr_ptr]   <= job_M;
            q_n[wr_ptr]   <= job_N;
            q_off[wr_ptr] <= job_offset;
            q_tag[wr_ptr] <= job_tag;
        end
    end

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + CW'(1);
        else if (pop && !push)
            count_next = count - CW'(1);
    end

    // job_ready is computed from the next count so it never depends on this cycle's pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            job_ready <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count     <= count_next;
            job_ready <= (count_next < CW'(DEPTH));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        rec_set    = 1'b0;
        rec_err    = 1'b0;
        case (state)
            IDLE: begin
                if (pop) begin
                    state_next = head_zero ? REPORT : LAUNCH;
                    rec_set    = head_zero;
                    rec_err    = 1'b1;
                end
            end
            LAUNCH: state_next = START;
            START: begin
                if (tpu_busy) begin
                    state_next = busy_last ? DRAIN : RUN;
                    rec_set    = busy_last;
                    rec_err    = 1'b1;
                end else if (wait_cnt == 32'(START_WAIT - 1)) begin
                    state_next = REPORT;
                    rec_set    = 1'b1;
                    rec_err    = 1'b1;
                end
            end
            RUN: begin
                if (!tpu_busy) begin
                    state_next = REPORT;
                    rec_set    = 1'b1;
                end else if (busy_last) begin
                    state_next = DRAIN;
                    rec_set    = 1'b1;
                    rec_err    = 1'b1;
                end
            end
            DRAIN: begin
                if (!tpu_busy)
                    state_next = (done_valid && !done_ready) ? REPORT : IDLE;
            end
            REPORT: begin
                if (done_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tpu_K      <= '0;
            tpu_M      <= '0;
            tpu_N      <= '0;
            tpu_offset <= '0;
            done_tag   <= '0;
            done_error <= 1'b0;
            done_valid <= 1'b0;
            cycles     <= '0;
            wait_cnt   <= '0;
        end else begin
            if (pop) begin
                done_tag <= q_tag[rd_ptr];
                cycles   <= '0;
                wait_cnt <= '0;
                // Zero-dimension jobs never reach the TPU, so the last launched values stay put.
                if (!head_zero) begin
                    tpu_K      <= q_k[rd_ptr];
                    tpu_M      <= q_m[rd_ptr];
                    tpu_N      <= q_n[rd_ptr];
                    tpu_offset <= q_off[rd_ptr];
                end
            end
            case (state)
                START: begin
                    if (tpu_busy)
                        cycles <= 32'd1;
                    else
                        wait_cnt <= wait_cnt + 32'd1;
                end
                RUN: begin
                    if (tpu_busy) cycles <= cycles + 32'd1;
                end
                default: ;
            endcase
            if (rec_set) begin
                done_valid <= 1'b1;
                done_error <= rec_err;
            end else if (done_valid && done_ready) begin
                done_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_tpu_job_sequencer.sv
// tb/tb_tpu_job_sequencer.sv - self-checking bench for tpu_job_sequencer with a reactive TPU model
module tb_tpu_job_sequencer;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 100;
    localparam int SWAIT   = 2;

    typedef struct {
        logic [7:0]  k, m, n;
        logic [31:0] off;
    } launch_t;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] cycles;
        logic        err;
    } done_t;

    logic        clk, reset;
    logic        job_valid, job_ready;
    logic [7:0]  job_K, job_M, job_N;
    logic [31:0] job_offset;
    logic [3:0]  job_tag;
    logic        tpu_in_valid;
    logic [7:0]  tpu_K, tpu_M, tpu_N;
    logic [31:0] tpu_offset;
    logic        tpu_busy;
    logic        done_valid, done_ready;
    logic [3:0]  done_tag;
    logic [31:0] done_cycles;
    logic        done_error;
    logic [2:0]  queue_count;
    logic        idle;

    int n_assert = 0;
    int n_fail   = 0;
    int launch_count = 0;
    int done_seen    = 0;
    launch_t exp_launch[$];
    done_t   exp_done[$];
    int      busy_plan[$];
    logic [31:0] last_off = 0;

    tpu_job_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT), .START_WAIT(SWAIT)) dut (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_K(job_K), .job_M(job_M), .job_N(job_N),
        .job_offset(job_offset), .job_tag(job_tag),
        .tpu_in_valid(tpu_in_valid), .tpu_K(tpu_K), .tpu_M(tpu_M), .tpu_N(tpu_N),
        .tpu_offset(tpu_offset), .tpu_busy(tpu_busy),
        .done_valid(done_valid), .done_ready(done_ready),
        .done_tag(done_tag), .done_cycles(done_cycles), .done_error(done_error),
        .queue_count(queue_count), .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference outcome of one job from its dimensions and how long the TPU stays busy.
    function automatic done_t expect_done(input logic [7:0] k, m, n, input logic [3:0] tag, input int len);
        done_t d;
        d.tag = tag;
        if (k == 0 || m == 0 || n == 0 || len == 0) begin
            d.cycles = 0;
            d.err    = 1'b1;
        end else if (len >= TIMEOUT) begin
            d.cycles = TIMEOUT;
            d.err    = 1'b1;
        end else begin
            d.cycles = len;
            d.err    = 1'b0;
        end
        return d;
    endfunction

    // TPU model: busy rises in the cycle after the launch pulse and is sampled high on exactly len edges.
    initial begin
        int len;
        tpu_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tpu_in_valid && !reset) begin
                len = (busy_plan.size() > 0) ? busy_plan.pop_front() : 0;
                if (len > 0) begin
                    @(posedge clk); #1 tpu_busy = 1'b1;
                    repeat (len) @(posedge clk);
                    #1 tpu_busy = 1'b0;
                end
            end
        end
    end

    // Launch and completion monitor.
    initial begin
        launch_t l;
        done_t   d;
        done_t   prev;
        bit      have_prev = 0;
        forever begin
            @(negedge clk); #1;
            if (reset) begin
                last_off  = 0;
                have_prev = 0;
            end else begin
                if (tpu_in_valid) begin
                    launch_count++;
                    check("launch_while_busy", tpu_busy, 0);
                    check("launch_while_done", done_valid, 0);
                    check("launch_expected", exp_launch.size() != 0, 1);
                    if (exp_launch.size() != 0) begin
                        l = exp_launch.pop_front();
                        check("launch_K", tpu_K, l.k);
                        check("launch_M", tpu_M, l.m);
                        check("launch_N", tpu_N, l.n);
                        check("launch_offset", tpu_offset, l.off);
                        last_off = l.off;
                    end
                end
                if (tpu_busy) check("offset_stable", tpu_offset, last_off);
                if (done_valid) begin
                    if (have_prev) begin
                        check("rec_stable_tag", done_tag, prev.tag);
                        check("rec_stable_cycles", done_cycles, prev.cycles);
                        check("rec_stable_err", done_error, prev.err);
                    end
                    prev.tag = done_tag; prev.cycles = done_cycles; prev.err = done_error;
                    have_prev = 1;
                    if (done_ready) begin
                        have_prev = 0;
                        done_seen++;
                        check("done_expected", exp_done.size() != 0, 1);
                        if (exp_done.size() != 0) begin
                            d = exp_done.pop_front();
                            check("done_tag", done_tag, d.tag);
                            check("done_cycles", done_cycles, d.cycles);
                            check("done_error", done_error, d.err);
                        end
                    end
                end else begin
                    have_prev = 0;
                end
            end
        end
    end

    task automatic push_job(input logic [7:0] k, m, n, input logic [31:0] off, input logic [3:0] tag, input int len);
        int t = 0;
        launch_t l;
        if (k != 0 && m != 0 && n != 0) begin
            l.k = k; l.m = m; l.n = n; l.off = off;
            exp_launch.push_back(l);
            busy_plan.push_back(len);
        end
        exp_done.push_back(expect_done(k, m, n, tag, len));
        job_valid = 1'b1; job_K = k; job_M = m; job_N = n; job_offset = off; job_tag = tag;
        while (!job_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("push_accepted", job_ready, 1);
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while (!(idle && !done_valid && !tpu_busy && exp_done.size() == 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check(tag, exp_done.size() == 0 && idle, 1);
        check("launches_consumed", exp_launch.size(), 0);
    endtask

    function automatic logic [7:0] rnd_dim();
        return ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
    endfunction

    initial begin
        int lc0, ds0, t, dv_seen, len;
        reset = 1'b1; job_valid = 1'b0; job_K = 0; job_M = 0; job_N = 0;
        job_offset = 0; job_tag = 0; done_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_idle", idle, 1);
        check("rst_job_ready", job_ready, 0);
        check("rst_done_valid", done_valid, 0);
        check("rst_in_valid", tpu_in_valid, 0);
        check("rst_queue_count", queue_count, 0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", job_ready, 1);

        // 1: single job, launch latency and result
        push_job(8'd4, 8'd4, 8'd4, 32'd128, 4'd3, 20);
        check("t1_queue_count", queue_count, 1);
        check("t1_no_early_launch", tpu_in_valid, 0);
        @(negedge clk);
        check("t1_launch_latency", tpu_in_valid, 1);
        wait_idle("t1_idle");
        check("t1_launch_count", launch_count, 1);
        check("t1_offset_held", tpu_offset, 128);

        // 2: fill the queue behind a long job
        lc0 = launch_count; ds0 = done_seen;
        push_job(8'd1, 8'd2, 8'd3, $urandom, 4'd1, 40);
        for (int i = 2; i <= 5; i++)
            push_job(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)),
                     $urandom, 4'(i), $urandom_range(1, 20));
        check("t2_queue_full", queue_count, 4);
        check("t2_ready_low", job_ready, 0);
        push_job(8'd6, 8'd6, 8'd6, $urandom, 4'd6, 5);
        check("t2_job6_after_report", done_seen - ds0 >= 1, 1);
        wait_idle("t2_idle");
        check("t2_launch_count", launch_count - lc0, 6);

        // 3: zero dimension skipped, next job launches
        lc0 = launch_count;
        push_job(8'd7, 8'd9, 8'd0, $urandom, 4'd5, 0);
        push_job(8'd2, 8'd2, 8'd2, $urandom, 4'd8, 7);
        wait_idle("t3_idle");
        check("t3_launch_count", launch_count - lc0, 1);

        // 4: busy never rises
        push_job(8'd3, 8'd3, 8'd3, $urandom, 4'd9, 0);
        wait_idle("t4_idle");

        // 5: timeout then drain before the next launch
        lc0 = launch_count;
        push_job(8'd5, 8'd5, 8'd5, $urandom, 4'd10, 150);
        push_job(8'd1, 8'd1, 8'd1, $urandom, 4'd11, 3);
        wait_idle("t5_idle");
        check("t5_launch_count", launch_count - lc0, 2);

        // 6: reset mid-run with two jobs queued
        push_job(8'd8, 8'd8, 8'd8, $urandom, 4'd12, 60);
        push_job(8'd8, 8'd8, 8'd9, $urandom, 4'd13, 60);
        push_job(8'd8, 8'd9, 8'd9, $urandom, 4'd14, 60);
        t = 0;
        while (!(tpu_busy && queue_count == 2) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("t6_running", tpu_busy && queue_count == 2, 1);
        reset = 1'b1;
        #1;
        check("t6_idle", idle, 1);
        check("t6_queue_count", queue_count, 0);
        check("t6_done_valid", done_valid, 0);
        check("t6_tpu_K", tpu_K, 0);
        check("t6_tpu_offset", tpu_offset, 0);
        check("t6_job_ready", job_ready, 0);
        exp_launch.delete(); exp_done.delete(); busy_plan.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        dv_seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (done_valid || tpu_in_valid) dv_seen++;
        end
        check("t6_no_report", dv_seen, 0);
        check("t6_idle_after", idle, 1);
        check("t6_busy_gone", tpu_busy, 0);

        // 7: host stalls the record
        done_ready = 1'b0;
        push_job(8'd4, 8'd5, 8'd6, $urandom, 4'd2, 5);
        push_job(8'd6, 8'd5, 8'd4, $urandom, 4'd4, 5);
        t = 0;
        while (!done_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("t7_record_up", done_valid, 1);
        repeat (10) begin
            @(negedge clk);
            check("t7_no_launch", tpu_in_valid, 0);
        end
        done_ready = 1'b1;
        @(negedge clk);
        check("t7_valid_cleared", done_valid, 0);
        check("t7_not_yet", tpu_in_valid, 0);
        @(negedge clk);
        check("t7_launch_after_ack", tpu_in_valid, 1);
        wait_idle("t7_idle");

        // random batch
        for (int i = 0; i < 12; i++) begin
            len = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 130);
            push_job(rnd_dim(), rnd_dim(), rnd_dim(), $urandom, 4'($urandom), len);
        end
        wait_idle("rand_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
